mii_tx_serializer: RTL

- Downstream neighbour of the frame builder: consumes its byte stream (preamble, SFD, header, payload), buffers it in a small FIFO and drives a 4-bit MII transmit interface, one nibble per clock.
- Optionally computes and appends the Ethernet FCS.
- Enforces the inter-frame gap and signals FIFO underrun on the wire.
- `clk` is the MII TX clock (25 MHz for 100BASE-TX).

---
 rtl/mii_tx_serializer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mii_tx_serializer.sv
// mii_tx_serializer: byte FIFO feeding a 4-bit MII transmitter with inter-frame gap and underrun handling.
// Define ETH_FCS_EN to append a CRC-32 FCS over the bytes following the SFD.
module mii_tx_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int IPG_BYTES  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] mii_txd,
    output logic       mii_tx_en,
    output logic       mii_tx_er,
    output logic       busy,
    output logic       underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(2 * IPG_BYTES + 8);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] IPG_END = CW'(2 * IPG_BYTES - 1);

    typedef enum logic [2:0] {IDLE, TX_LO, TX_HI, FCS, ERR, FLUSH, IPG} state_t;
`ifdef ETH_FCS_EN
    localparam state_t AFTER_LAST = FCS;
`else
    localparam state_t AFTER_LAST = IPG;
`endif

    state_t        r_state, w_next;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt, r_lcnt;
    logic [7:0]    r_byte;
    logic          r_last, r_rdy;
    logic [CW-1:0] r_cyc;
    logic [8:0]    w_head;
    logic [3:0]    w_txd, w_fcs;
    logic          w_en, w_er, w_pop, w_push, w_empty, w_start;

    assign w_head   = r_mem[r_rp];
    assign w_empty  = r_cnt == '0;
    assign w_start  = (r_cnt == FULL) || (r_lcnt != '0);
    // FLUSH pops every cycle it has data, so it can accept even when full
    assign in_ready = r_rdy & ((r_cnt != FULL) | (r_state == FLUSH));
    assign w_push   = in_valid & in_ready;
    assign busy     = r_state != IDLE;

`ifdef ETH_FCS_EN
    logic [31:0] r_crc, w_crc_n;
    logic [10:0] r_bcnt;
    logic        r_cov;

    function automatic logic [31:0] crc4(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] x;
        x = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++) x = x[0] ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
        return x;
    endfunction

    assign w_crc_n = ~r_crc >> {r_cyc[2:0], 2'b00};
    assign w_fcs   = w_crc_n[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc  <= '1;
            r_bcnt <= '0;
            r_cov  <= 1'b0;
        end else if (r_state == TX_LO) begin
            r_cov  <= r_bcnt >= 11'd8;
            r_bcnt <= r_bcnt + 11'(r_bcnt != '1);
            if (r_bcnt >= 11'd8) r_crc <= crc4(r_crc, w_head[3:0]);
        end else if (r_state == TX_HI) begin
            if (r_cov) r_crc <= crc4(r_crc, r_byte[7:4]);
        end else if (r_state != FCS) begin
            r_crc  <= '1;
            r_bcnt <= '0;
        end
    end
`else
    assign w_fcs = 4'd0;
`endif

    always_comb begin
        w_next = r_state;
        w_txd  = 4'd0;
        w_en   = 1'b0;
        w_er   = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            IDLE:  w_next = w_start ? TX_LO : IDLE;
            TX_LO: begin
                w_pop  = 1'b1;
                w_txd  = w_head[3:0];
                w_en   = 1'b1;
                w_next = TX_HI;
            end
            TX_HI: begin
                w_txd  = r_byte[7:4];
                w_en   = 1'b1;
                w_next = r_last ? AFTER_LAST : (w_empty ? ERR : TX_LO);
            end
            FCS: begin
                w_txd  = w_fcs;
                w_en   = 1'b1;
                w_next = (r_cyc == CW'(7)) ? IPG : FCS;
            end
            // a broken frame is always discarded through its last byte
            ERR: begin
                w_en   = 1'b1;
                w_er   = 1'b1;
                w_next = FLUSH;
            end
            FLUSH: begin
                w_pop  = !w_empty;
                w_next = (!w_empty && w_head[8]) ? IPG : FLUSH;
            end
            IPG:     w_next = (r_cyc == IPG_END) ? (w_start ? TX_LO : IDLE) : IPG;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {in_last, in_byte};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_lcnt    <= '0;
            r_byte    <= '0;
            r_last    <= 1'b0;
            r_rdy     <= 1'b0;
            r_cyc     <= '0;
            mii_txd   <= 4'd0;
            mii_tx_en <= 1'b0;
            mii_tx_er <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rdy   <= 1'b1;
            r_cyc   <= (w_next != r_state) ? '0 : r_cyc + CW'(1);
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt  <= r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
            r_lcnt <= r_lcnt + (AW + 1)'(w_push & in_last) - (AW + 1)'(w_pop & w_head[8]);
            if (r_state == TX_LO) {r_last, r_byte} <= w_head;
            mii_txd   <= w_txd;
            mii_tx_en <= w_en;
            mii_tx_er <= w_er;
            underrun  <= w_er;
        end
    end
endmodule
